// File: rtl/ns_arb_2to1.sv
// ns_arb_2to1: two-input round-robin arbiter merging two four-phase req/ack
// message channels (src/dst/dat/red) onto one registered output channel.
// Optional redundancy check on captured messages: define NS_ARB_REDUN_CHK_EN.

`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 8
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 16
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 4
`endif

`ifdef NS_ARB_REDUN_CHK_EN
// XOR-folds {src,dst,dat} down to RSZ bits.
module calc_redun #(
  parameter int unsigned ASZ = `NS_ADDRESS_SIZE,
  parameter int unsigned DSZ = `NS_DATA_SIZE,
  parameter int unsigned RSZ = `NS_REDUN_SIZE
) (
  input  logic [ASZ-1:0] src_i,
  input  logic [ASZ-1:0] dst_i,
  input  logic [DSZ-1:0] dat_i,
  output logic [RSZ-1:0] red_o
);
  localparam int unsigned MW = 2 * ASZ + DSZ;

  logic [MW-1:0] msg;

  // Fold every message bit onto redundancy bit (index mod RSZ).
  always_comb begin
    msg   = {src_i, dst_i, dat_i};
    red_o = '0;
    for (int unsigned b = 0; b < MW; b += RSZ) begin
      for (int unsigned r = 0; r < RSZ; r++) begin
        if (b + r < MW) begin
          red_o[r] = red_o[r] ^ msg[b + r];
        end
      end
    end
  end
endmodule
`endif

module ns_arb_2to1 #(
  parameter int unsigned ASZ       = `NS_ADDRESS_SIZE,
  parameter int unsigned DSZ       = `NS_DATA_SIZE,
  parameter int unsigned RSZ       = `NS_REDUN_SIZE,
  parameter int unsigned FIRST_GNT = 0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [ASZ-1:0] i0_src,
  input  logic [ASZ-1:0] i0_dst,
  input  logic [DSZ-1:0] i0_dat,
  input  logic [RSZ-1:0] i0_red,
  input  logic           i0_req,
  output logic           i0_ack,
  input  logic [ASZ-1:0] i1_src,
  input  logic [ASZ-1:0] i1_dst,
  input  logic [DSZ-1:0] i1_dat,
  input  logic [RSZ-1:0] i1_red,
  input  logic           i1_req,
  output logic           i1_ack,
  output logic [ASZ-1:0] o0_src,
  output logic [ASZ-1:0] o0_dst,
  output logic [DSZ-1:0] o0_dat,
  output logic [RSZ-1:0] o0_red,
  output logic           o0_req,
  input  logic           o0_ack,
  output logic           busy,
  output logic [7:0]     gnt_cnt0,
  output logic [7:0]     gnt_cnt1,
  output logic           err
`ifdef NS_ARB_REDUN_CHK_EN
  ,
  output logic [7:0]     red_err_cnt
`endif
);

`ifdef NS_ARB_REDUN_CHK_EN
  typedef enum logic [1:0] {ST_IDLE, ST_OUT_REQ, ST_OUT_REL, ST_CHECK} state_e;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_OUT_REQ, ST_OUT_REL} state_e;
`endif

  localparam logic LAST_GNT_RST = 1'(FIRST_GNT == 0);

  state_e         state_q;
  logic           i0_ack_q, i1_ack_q, o0_req_q, busy_q, err_q, last_gnt_q;
  logic [ASZ-1:0] o0_src_q, o0_dst_q;
  logic [DSZ-1:0] o0_dat_q;
  logic [RSZ-1:0] o0_red_q;
  logic [7:0]     gnt_cnt0_q, gnt_cnt1_q;

  logic           elig0, elig1, gnt_vld, gnt_sel;
  logic [ASZ-1:0] sel_src, sel_dst;
  logic [DSZ-1:0] sel_dat;
  logic [RSZ-1:0] sel_red;

`ifdef NS_ARB_REDUN_CHK_EN
  logic [7:0]     red_err_cnt_q;
  logic [RSZ-1:0] red_calc;

  calc_redun #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) u_calc_redun (
    .src_i (o0_src_q),
    .dst_i (o0_dst_q),
    .dat_i (o0_dat_q),
    .red_o (red_calc)
  );
`endif

  // Eligibility, round-robin pick and selected-message mux.
  always_comb begin
    elig0   = i0_req & ~i0_ack_q;
    elig1   = i1_req & ~i1_ack_q;
    gnt_vld = elig0 | elig1;
    gnt_sel = (elig0 & elig1) ? ~last_gnt_q : elig1;
    sel_src = gnt_sel ? i1_src : i0_src;
    sel_dst = gnt_sel ? i1_dst : i0_dst;
    sel_dat = gnt_sel ? i1_dat : i0_dat;
    sel_red = gnt_sel ? i1_red : i0_red;
  end

  // Arbitration FSM, input ack release and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      i0_ack_q   <= 1'b0;
      i1_ack_q   <= 1'b0;
      o0_req_q   <= 1'b0;
      o0_src_q   <= '0;
      o0_dst_q   <= '0;
      o0_dat_q   <= '0;
      o0_red_q   <= '0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      gnt_cnt0_q <= '0;
      gnt_cnt1_q <= '0;
      last_gnt_q <= LAST_GNT_RST;
`ifdef NS_ARB_REDUN_CHK_EN
      red_err_cnt_q <= '0;
`endif
    end else begin
      // Acks drop once the sender has withdrawn its request.
      if (i0_ack_q && !i0_req) i0_ack_q <= 1'b0;
      if (i1_ack_q && !i1_req) i1_ack_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (o0_ack) err_q <= 1'b1;
          if (gnt_vld) begin
            o0_src_q   <= sel_src;
            o0_dst_q   <= sel_dst;
            o0_dat_q   <= sel_dat;
            o0_red_q   <= sel_red;
            last_gnt_q <= gnt_sel;
            busy_q     <= 1'b1;
            if (gnt_sel) begin
              i1_ack_q   <= 1'b1;
              gnt_cnt1_q <= gnt_cnt1_q + 8'd1;
            end else begin
              i0_ack_q   <= 1'b1;
              gnt_cnt0_q <= gnt_cnt0_q + 8'd1;
            end
`ifdef NS_ARB_REDUN_CHK_EN
            state_q  <= ST_CHECK;
`else
            o0_req_q <= 1'b1;
            state_q  <= ST_OUT_REQ;
`endif
          end
        end
`ifdef NS_ARB_REDUN_CHK_EN
        ST_CHECK: begin
          if (red_calc != o0_red_q) begin
            err_q         <= 1'b1;
            red_err_cnt_q <= red_err_cnt_q + 8'd1;
            busy_q        <= 1'b0;
            state_q       <= ST_IDLE;
          end else begin
            o0_req_q <= 1'b1;
            state_q  <= ST_OUT_REQ;
          end
        end
`endif
        ST_OUT_REQ: begin
          if (o0_ack) begin
            o0_req_q <= 1'b0;
            state_q  <= ST_OUT_REL;
          end
        end
        ST_OUT_REL: begin
          if (!o0_ack) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          o0_req_q <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

  assign i0_ack   = i0_ack_q;
  assign i1_ack   = i1_ack_q;
  assign o0_req   = o0_req_q;
  assign o0_src   = o0_src_q;
  assign o0_dst   = o0_dst_q;
  assign o0_dat   = o0_dat_q;
  assign o0_red   = o0_red_q;
  assign busy     = busy_q;
  assign err      = err_q;
  assign gnt_cnt0 = gnt_cnt0_q;
  assign gnt_cnt1 = gnt_cnt1_q;
`ifdef NS_ARB_REDUN_CHK_EN
  assign red_err_cnt = red_err_cnt_q;
`endif

endmodule

// File: tb/tb_ns_arb_2to1.sv
// Directed self-checking bench for ns_arb_2to1.

`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 8
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 16
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 4
`endif

module tb_ns_arb_2to1;
  localparam int ASZ = `NS_ADDRESS_SIZE;
  localparam int DSZ = `NS_DATA_SIZE;
  localparam int RSZ = `NS_REDUN_SIZE;
`ifdef NS_ARB_REDUN_CHK_EN
  localparam int CHK_LAT = 1;
`else
  localparam int CHK_LAT = 0;
`endif

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [ASZ-1:0] i0_src = '0, i0_dst = '0, i1_src = '0, i1_dst = '0;
  logic [DSZ-1:0] i0_dat = '0, i1_dat = '0;
  logic [RSZ-1:0] i0_red = '0, i1_red = '0;
  logic           i0_req = 1'b0, i1_req = 1'b0, o0_ack = 1'b0;
  logic           i0_ack, i1_ack, o0_req, busy, err;
  logic [ASZ-1:0] o0_src, o0_dst;
  logic [DSZ-1:0] o0_dat;
  logic [RSZ-1:0] o0_red;
  logic [7:0]     gnt_cnt0, gnt_cnt1;
`ifdef NS_ARB_REDUN_CHK_EN
  logic [7:0]     red_err_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  // Reactive source/sink models, stepped from tick()
  bit auto0 = 0, auto1 = 0, auto_sink = 0;
  int left0 = 0, left1 = 0, msg0 = 0, msg1 = 0;
  int sink_dly = 0, wcnt = 0;
  bit mon_prev = 0;
  int log_q[$];

  always #5 clk = ~clk;

  ns_arb_2to1 #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ), .FIRST_GNT(0)) dut (
    .clk(clk), .reset(reset),
    .i0_src(i0_src), .i0_dst(i0_dst), .i0_dat(i0_dat), .i0_red(i0_red),
    .i0_req(i0_req), .i0_ack(i0_ack),
    .i1_src(i1_src), .i1_dst(i1_dst), .i1_dat(i1_dat), .i1_red(i1_red),
    .i1_req(i1_req), .i1_ack(i1_ack),
    .o0_src(o0_src), .o0_dst(o0_dst), .o0_dat(o0_dat), .o0_red(o0_red),
    .o0_req(o0_req), .o0_ack(o0_ack),
    .busy(busy), .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1), .err(err)
`ifdef NS_ARB_REDUN_CHK_EN
    , .red_err_cnt(red_err_cnt)
`endif
  );

  function automatic logic [RSZ-1:0] fold(input logic [ASZ-1:0] s, input logic [ASZ-1:0] d,
                                          input logic [DSZ-1:0] t);
    logic [2*ASZ+DSZ-1:0] m;
    logic [RSZ-1:0] r;
    m = {s, d, t};
    r = '0;
    for (int i = 0; i < 2*ASZ+DSZ; i++) r[i % RSZ] = r[i % RSZ] ^ m[i];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drv0(input logic [ASZ-1:0] s, input logic [ASZ-1:0] d, input logic [DSZ-1:0] t);
    i0_src = s; i0_dst = d; i0_dat = t; i0_red = fold(s, d, t);
  endtask

  task automatic drv1(input logic [ASZ-1:0] s, input logic [ASZ-1:0] d, input logic [DSZ-1:0] t);
    i1_src = s; i1_dst = d; i1_dat = t; i1_red = fold(s, d, t);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (o0_req && !mon_prev) log_q.push_back(int'(o0_src));
    mon_prev = o0_req;
    if (auto0) begin
      if (i0_req && i0_ack) i0_req = 1'b0;
      else if (!i0_req && !i0_ack && left0 > 0) begin
        drv0(ASZ'(0), ASZ'(2), DSZ'(msg0)); msg0++; left0--; i0_req = 1'b1;
      end
    end
    if (auto1) begin
      if (i1_req && i1_ack) i1_req = 1'b0;
      else if (!i1_req && !i1_ack && left1 > 0) begin
        drv1(ASZ'(1), ASZ'(2), DSZ'(msg1)); msg1++; left1--; i1_req = 1'b1;
      end
    end
    if (auto_sink) begin
      if (o0_req && !o0_ack) begin
        if (wcnt >= sink_dly) o0_ack = 1'b1;
        else wcnt++;
      end else if (!o0_req && o0_ack) begin
        o0_ack = 1'b0; wcnt = 0;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    auto0 = 0; auto1 = 0; auto_sink = 0;
    i0_req = 1'b0; i1_req = 1'b0; o0_ack = 1'b0;
    drv0('0, '0, '0); drv1('0, '0, '0);
    wcnt = 0; sink_dly = 0; mon_prev = 0; log_q.delete();
    tick(); tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    int n;
    // Reset state while reset is held low
    #12;
    chk("rst_o0_req", 32'(o0_req), 32'd0);
    chk("rst_acks", 32'({i0_ack, i1_ack}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_cnts", 32'({gnt_cnt0, gnt_cnt1}), 32'd0);
    chk("rst_fields", 32'({o0_src, o0_dst, o0_dat} != 0), 32'd0);

    // Single message from i0
    do_reset();
    drv0(ASZ'(0), ASZ'(1), DSZ'(5)); i0_req = 1'b1;
    tick();
    repeat (CHK_LAT) tick();
    chk("t1_o0_req", 32'(o0_req), 32'd1);
    chk("t1_dst", 32'(o0_dst), 32'd1);
    chk("t1_dat", 32'(o0_dat), 32'd5);
    chk("t1_i0_ack", 32'(i0_ack), 32'd1);
    chk("t1_gnt0", 32'(gnt_cnt0), 32'd1);
    chk("t1_i1_ack", 32'(i1_ack), 32'd0);
    chk("t1_busy", 32'(busy), 32'd1);

    // Both inputs streaming, zero-delay sink: strict alternation
    do_reset();
    left0 = 8; left1 = 8; msg0 = 0; msg1 = 0; auto0 = 1; auto1 = 1; auto_sink = 1;
    n = 0;
    while (log_q.size() < 16 && n < 400) begin tick(); n++; end
    repeat (6) tick();
    chk("t2_msgs", 32'(log_q.size()), 32'd16);
    for (int k = 0; k < 16 && k < log_q.size(); k++) chk($sformatf("t2_order%0d", k), 32'(log_q[k]), 32'(k % 2));
    chk("t2_gnt0", 32'(gnt_cnt0), 32'd8);
    chk("t2_gnt1", 32'(gnt_cnt1), 32'd8);
    chk("t2_err", 32'(err), 32'd0);
    chk("t2_busy", 32'(busy), 32'd0);

    // Slow sink: fields held, i1 waits for the full release
    do_reset();
    sink_dly = 10; auto_sink = 1;
    drv0(ASZ'(0), ASZ'(3), DSZ'(16'h00A1)); i0_req = 1'b1;
    tick();
    repeat (CHK_LAT) tick();
    chk("t3_req_0", 32'(o0_req), 32'd1);
    chk("t3_dat_0", 32'(o0_dat), 32'h00A1);
    i0_req = 1'b0;
    drv1(ASZ'(1), ASZ'(4), DSZ'(16'h00B2)); i1_req = 1'b1;
    for (int k = 1; k < 10; k++) begin
      tick();
      chk($sformatf("t3_req_%0d", k), 32'(o0_req), 32'd1);
      chk($sformatf("t3_dat_%0d", k), 32'(o0_dat), 32'h00A1);
      chk($sformatf("t3_i1ack_%0d", k), 32'(i1_ack), 32'd0);
    end
    n = 0;
    while (!i1_ack && n < 50) begin tick(); n++; end
    chk("t3_i1_wait", 32'(n), 32'd4);
    chk("t3_i1_dat", 32'(o0_dat), 32'h00B2);
    chk("t3_gnt1", 32'(gnt_cnt1), 32'd1);
    i1_req = 1'b0;
    repeat (20) tick();

    // Held request: no second grant until req drops
    do_reset();
    auto_sink = 1;
    drv0(ASZ'(0), ASZ'(1), DSZ'(1)); i0_req = 1'b1;
    tick();
    repeat (CHK_LAT) tick();
    chk("t4_gnt0_a", 32'(gnt_cnt0), 32'd1);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("t4_hold_gnt%0d", k), 32'(gnt_cnt0), 32'd1);
      chk($sformatf("t4_hold_ack%0d", k), 32'(i0_ack), 32'd1);
    end
    chk("t4_idle", 32'(busy), 32'd0);
    i0_req = 1'b0;
    tick();
    chk("t4_ack_drop", 32'(i0_ack), 32'd0);
    drv0(ASZ'(0), ASZ'(1), DSZ'(2)); i0_req = 1'b1;
    tick();
    repeat (CHK_LAT) tick();
    chk("t4_gnt0_b", 32'(gnt_cnt0), 32'd2);
    chk("t4_dat_b", 32'(o0_dat), 32'd2);
    chk("t4_ack_b", 32'(i0_ack), 32'd1);
    i0_req = 1'b0;
    repeat (6) tick();

    // Asynchronous reset in the middle of a transfer
    do_reset();
    drv0(ASZ'(0), ASZ'(1), DSZ'(7)); i0_req = 1'b1;
    drv1(ASZ'(1), ASZ'(1), DSZ'(8)); i1_req = 1'b1;
    tick();
    repeat (CHK_LAT) tick();
    chk("t5_busy_pre", 32'(busy), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("t5_o0_req", 32'(o0_req), 32'd0);
    chk("t5_acks", 32'({i0_ack, i1_ack}), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_cnts", 32'({gnt_cnt0, gnt_cnt1}), 32'd0);
    i0_req = 1'b0; i1_req = 1'b0;
    tick();
    reset = 1'b1;
    tick();

    // o0_ack while idle sets sticky err only
    do_reset();
    o0_ack = 1'b1;
    tick();
    chk("t6_err", 32'(err), 32'd1);
    chk("t6_busy", 32'(busy), 32'd0);
    o0_ack = 1'b0;
    tick();
    chk("t6_err_sticky", 32'(err), 32'd1);
    chk("t6_o0_req", 32'(o0_req), 32'd0);

`ifdef NS_ARB_REDUN_CHK_EN
    // Corrupted redundancy from i1: message discarded
    do_reset();
    auto_sink = 1;
    drv1(ASZ'(1), ASZ'(2), DSZ'(16'h0033));
    i1_red = i1_red ^ RSZ'(1);
    i1_req = 1'b1;
    tick();
    chk("t7_i1_ack", 32'(i1_ack), 32'd1);
    tick();
    chk("t7_o0_req", 32'(o0_req), 32'd0);
    chk("t7_err", 32'(err), 32'd1);
    chk("t7_red_cnt", 32'(red_err_cnt), 32'd1);
    chk("t7_busy", 32'(busy), 32'd0);
    i1_req = 1'b0;
    tick();
    chk("t7_i1_ack_rel", 32'(i1_ack), 32'd0);
    chk("t7_no_fwd", 32'(log_q.size()), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
